// File: rtl/core_pkg.sv
// Shared constants for the RV32I core pipeline.
//   FWD_*     : operand bypass select encodings driven by forward_unit
//   ALU_OP_*  : coarse ALU operation class handed to the ALU controller
//   OPCODE_*  : major opcodes used by decode and the execute stage
//   fwd_hit() : one bypass source matches a consuming register index
package core_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_SUB   = 2'd1;
  localparam logic [1:0] ALU_OP_RTYPE = 2'd2;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  // A producer matches only if it writes a register other than x0.
  function automatic logic fwd_hit(input logic [4:0] rs, input logic [4:0] rd,
                                   input logic reg_write);
    return reg_write && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand bypass selector for one EX source register.
//   rs_ex         : register index read by the instruction in EX
//   rd_mem        : destination of the instruction in MEM
//   reg_write_mem : MEM instruction writes the register file
//   rd_wb         : destination of the instruction in WB
//   reg_write_wb  : WB instruction writes the register file
//   fwd_sel       : FWD_MEM, FWD_WB or FWD_REG
// The younger MEM result wins over WB when both match.
module forward_unit
  import core_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_ex,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic                  reg_write_mem,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  reg_write_wb,
  output logic [1:0]            fwd_sel
);

  logic hit_mem;
  logic hit_wb;

  always_comb begin
    hit_mem = reg_write_mem && (rd_mem != '0) && (rd_mem == rs_ex);
    hit_wb  = reg_write_wb && (rd_wb != '0) && (rd_wb == rs_ex);
    fwd_sel = FWD_REG;
    if (hit_mem) begin
      fwd_sel = FWD_MEM;
    end else if (hit_wb) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and load-use detection.
//   clk, rst            : core clock, asynchronous active-high reset
//   stall_in, flush     : global freeze; squash of the instruction entering EX
//   *_id                : decoded instruction fields from ID
//   rd/reg_write/alu_result_mem, rd/reg_write/result_wb : bypass sources
//   *_ex                : registered EX-stage fields for the ALU controller / MEM
//   src_a, src_b        : forwarded ALU operands (src_b may be the immediate)
//   store_data_ex       : forwarded rs2 for stores
//   forward_a/forward_b : bypass selects (00 regfile, 01 WB, 10 MEM)
//   load_use_stall      : combinational hold request for PC and IF/ID
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_in,
  input  logic                  flush,
  input  logic                  valid_id,
  input  logic [XLEN-1:0]       pc_id,
  input  logic [XLEN-1:0]       rs1_data_id,
  input  logic [XLEN-1:0]       rs2_data_id,
  input  logic [XLEN-1:0]       imm_id,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic [2:0]            funct3_id,
  input  logic [6:0]            funct7_id,
  input  logic [6:0]            opcode_id,
  input  logic [1:0]            alu_op_id,
  input  logic                  alu_src_id,
  input  logic                  reg_write_id,
  input  logic                  mem_read_id,
  input  logic                  mem_write_id,
  input  logic                  mem_to_reg_id,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic                  reg_write_mem,
  input  logic [XLEN-1:0]       alu_result_mem,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  reg_write_wb,
  input  logic [XLEN-1:0]       result_wb,
  output logic                  valid_ex,
  output logic [XLEN-1:0]       pc_ex,
  output logic [XLEN-1:0]       imm_ex,
  output logic [2:0]            funct3_ex,
  output logic [6:0]            funct7_ex,
  output logic [6:0]            opcode_ex,
  output logic [1:0]            alu_op_ex,
  output logic [REG_ADDR_W-1:0] rd_ex,
  output logic                  reg_write_ex,
  output logic                  mem_read_ex,
  output logic                  mem_write_ex,
  output logic                  mem_to_reg_ex,
  output logic [XLEN-1:0]       src_a,
  output logic [XLEN-1:0]       src_b,
  output logic [XLEN-1:0]       store_data_ex,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  load_use_stall
);

  logic                  valid_q,      valid_d;
  logic [XLEN-1:0]       pc_q,         pc_d;
  logic [XLEN-1:0]       imm_q,        imm_d;
  logic [XLEN-1:0]       rs1_data_q,   rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q,   rs2_data_d;
  logic [REG_ADDR_W-1:0] rs1_q,        rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q,        rs2_d;
  logic [REG_ADDR_W-1:0] rd_q,         rd_d;
  logic [2:0]            funct3_q,     funct3_d;
  logic [6:0]            funct7_q,     funct7_d;
  logic [6:0]            opcode_q,     opcode_d;
  logic [1:0]            alu_op_q,     alu_op_d;
  logic                  alu_src_q,    alu_src_d;
  logic                  reg_write_q,  reg_write_d;
  logic                  mem_read_q,   mem_read_d;
  logic                  mem_write_q,  mem_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Conservative: rs2 is compared even for instructions that do not read it.
  // Squashed ID instructions never stall.
  always_comb begin
    load_use_stall = valid_q && mem_read_q && (rd_q != '0) && valid_id &&
                     ((rd_q == rs1_id) || (rd_q == rs2_id)) && !flush;
  end

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    funct3_d     = funct3_q;
    funct7_d     = funct7_q;
    opcode_d     = opcode_q;
    alu_op_d     = alu_op_q;
    alu_src_d    = alu_src_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    if (stall_in) begin
      // Freeze; a concurrent flush is re-presented by its source later.
    end else if (flush || load_use_stall) begin
      valid_d      = 1'b0;
      pc_d         = '0;
      imm_d        = '0;
      rs1_data_d   = '0;
      rs2_data_d   = '0;
      rs1_d        = '0;
      rs2_d        = '0;
      rd_d         = '0;
      funct3_d     = '0;
      funct7_d     = '0;
      opcode_d     = '0;
      alu_op_d     = ALU_OP_ADD;
      alu_src_d    = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else begin
      valid_d      = valid_id;
      pc_d         = pc_id;
      imm_d        = imm_id;
      rs1_data_d   = rs1_data_id;
      rs2_data_d   = rs2_data_id;
      rs1_d        = rs1_id;
      rs2_d        = rs2_id;
      rd_d         = rd_id;
      funct3_d     = funct3_id;
      funct7_d     = funct7_id;
      opcode_d     = opcode_id;
      alu_op_d     = alu_op_id;
      alu_src_d    = alu_src_id;
      reg_write_d  = reg_write_id;
      mem_read_d   = mem_read_id;
      mem_write_d  = mem_write_id;
      mem_to_reg_d = mem_to_reg_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      imm_q        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      funct3_q     <= '0;
      funct7_q     <= '0;
      opcode_q     <= '0;
      alu_op_q     <= '0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      funct3_q     <= funct3_d;
      funct7_q     <= funct7_d;
      opcode_q     <= opcode_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  forward_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_a (
    .rs_ex        (rs1_q),
    .rd_mem       (rd_mem),
    .reg_write_mem(reg_write_mem),
    .rd_wb        (rd_wb),
    .reg_write_wb (reg_write_wb),
    .fwd_sel      (forward_a)
  );

  forward_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_b (
    .rs_ex        (rs2_q),
    .rd_mem       (rd_mem),
    .reg_write_mem(reg_write_mem),
    .rd_wb        (rd_wb),
    .reg_write_wb (reg_write_wb),
    .fwd_sel      (forward_b)
  );

  always_comb begin
    unique case (forward_a)
      FWD_MEM: fwd_rs1 = alu_result_mem;
      FWD_WB:  fwd_rs1 = result_wb;
      default: fwd_rs1 = rs1_data_q;
    endcase
    unique case (forward_b)
      FWD_MEM: fwd_rs2 = alu_result_mem;
      FWD_WB:  fwd_rs2 = result_wb;
      default: fwd_rs2 = rs2_data_q;
    endcase
  end

  always_comb begin
    src_a         = fwd_rs1;
    src_b         = alu_src_q ? imm_q : fwd_rs2;
    store_data_ex = fwd_rs2;
  end

  always_comb begin
    valid_ex      = valid_q;
    pc_ex         = pc_q;
    imm_ex        = imm_q;
    funct3_ex     = funct3_q;
    funct7_ex     = funct7_q;
    opcode_ex     = opcode_q;
    alu_op_ex     = alu_op_q;
    rd_ex         = rd_q;
    reg_write_ex  = reg_write_q;
    mem_read_ex   = mem_read_q;
    mem_write_ex  = mem_write_q;
    mem_to_reg_ex = mem_to_reg_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset/bubble, forwarding priority, x0 guard,
// load-use stall, flush versus stall, immediate select and store data.
module tb_id_ex_stage;
  import core_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall_in, flush, valid_id;
  logic [XLEN-1:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
  logic [RW-1:0]   rs1_id, rs2_id, rd_id;
  logic [2:0]      funct3_id;
  logic [6:0]      funct7_id, opcode_id;
  logic [1:0]      alu_op_id;
  logic            alu_src_id, reg_write_id, mem_read_id, mem_write_id, mem_to_reg_id;
  logic [RW-1:0]   rd_mem, rd_wb;
  logic            reg_write_mem, reg_write_wb;
  logic [XLEN-1:0] alu_result_mem, result_wb;
  logic            valid_ex;
  logic [XLEN-1:0] pc_ex, imm_ex;
  logic [2:0]      funct3_ex;
  logic [6:0]      funct7_ex, opcode_ex;
  logic [1:0]      alu_op_ex;
  logic [RW-1:0]   rd_ex;
  logic            reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex;
  logic [XLEN-1:0] src_a, src_b, store_data_ex;
  logic [1:0]      forward_a, forward_b;
  logic            load_use_stall;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .XLEN      (XLEN),
    .REG_ADDR_W(RW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_in      (stall_in),
    .flush         (flush),
    .valid_id      (valid_id),
    .pc_id         (pc_id),
    .rs1_data_id   (rs1_data_id),
    .rs2_data_id   (rs2_data_id),
    .imm_id        (imm_id),
    .rs1_id        (rs1_id),
    .rs2_id        (rs2_id),
    .rd_id         (rd_id),
    .funct3_id     (funct3_id),
    .funct7_id     (funct7_id),
    .opcode_id     (opcode_id),
    .alu_op_id     (alu_op_id),
    .alu_src_id    (alu_src_id),
    .reg_write_id  (reg_write_id),
    .mem_read_id   (mem_read_id),
    .mem_write_id  (mem_write_id),
    .mem_to_reg_id (mem_to_reg_id),
    .rd_mem        (rd_mem),
    .reg_write_mem (reg_write_mem),
    .alu_result_mem(alu_result_mem),
    .rd_wb         (rd_wb),
    .reg_write_wb  (reg_write_wb),
    .result_wb     (result_wb),
    .valid_ex      (valid_ex),
    .pc_ex         (pc_ex),
    .imm_ex        (imm_ex),
    .funct3_ex     (funct3_ex),
    .funct7_ex     (funct7_ex),
    .opcode_ex     (opcode_ex),
    .alu_op_ex     (alu_op_ex),
    .rd_ex         (rd_ex),
    .reg_write_ex  (reg_write_ex),
    .mem_read_ex   (mem_read_ex),
    .mem_write_ex  (mem_write_ex),
    .mem_to_reg_ex (mem_to_reg_ex),
    .src_a         (src_a),
    .src_b         (src_b),
    .store_data_ex (store_data_ex),
    .forward_a     (forward_a),
    .forward_b     (forward_b),
    .load_use_stall(load_use_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample 1ns later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic [6:0] op, input logic [1:0] aop, input logic asrc,
                        input logic rw, input logic mr, input logic mw, input logic m2r);
    valid_id = v; pc_id = pc; rs1_data_id = d1; rs2_data_id = d2; imm_id = imm;
    rs1_id = r1; rs2_id = r2; rd_id = rd; opcode_id = op; alu_op_id = aop;
    alu_src_id = asrc; reg_write_id = rw; mem_read_id = mr; mem_write_id = mw;
    mem_to_reg_id = m2r; funct3_id = 3'd2; funct7_id = 7'h20;
  endtask

  task automatic clr_bypass();
    rd_mem = '0; reg_write_mem = 1'b0; alu_result_mem = '0;
    rd_wb = '0; reg_write_wb = 1'b0; result_wb = '0;
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
    set_id(1'b0, 0, 0, 0, 0, 0, 0, 0, 7'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_bypass();
    #12;
    chk("reset_valid", {31'd0, valid_ex}, 32'd0);
    chk("reset_pc", pc_ex, 32'd0);
    rst = 1'b0;

    // add x5,x5,x6
    set_id(1'b1, 32'h100, 32'hAAAA, 32'hBBBB, 32'h0, 5'd5, 5'd6, 5'd5, OPCODE_OP,
           ALU_OP_RTYPE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("load_valid", {31'd0, valid_ex}, 32'd1);
    chk("load_pc", pc_ex, 32'h100);
    chk("load_rd", {27'd0, rd_ex}, 32'd5);
    chk("load_aluop", {30'd0, alu_op_ex}, 32'd2);
    chk("load_opcode", {25'd0, opcode_ex}, {25'd0, OPCODE_OP});
    chk("load_f3", {29'd0, funct3_ex}, 32'd2);
    chk("load_f7", {25'd0, funct7_ex}, 32'h20);
    chk("nofwd_src_a", src_a, 32'hAAAA);
    chk("nofwd_src_b", src_b, 32'hBBBB);

    // Mid-cycle asynchronous reset
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, valid_ex}, 32'd0);
    chk("arst_regwrite", {31'd0, reg_write_ex}, 32'd0);
    chk("arst_memread", {31'd0, mem_read_ex}, 32'd0);
    chk("arst_pc", pc_ex, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", {31'd0, valid_ex}, 32'd1);
    chk("post_rst_pc", pc_ex, 32'h100);

    // MEM over WB priority
    rd_mem = 5'd5; reg_write_mem = 1'b1; alu_result_mem = 32'h11;
    rd_wb = 5'd5; reg_write_wb = 1'b1; result_wb = 32'h22;
    #1;
    chk("prio_fwd_a", {30'd0, forward_a}, 32'b10);
    chk("prio_src_a", src_a, 32'h11);
    chk("prio_fwd_b", {30'd0, forward_b}, 32'b00);
    reg_write_mem = 1'b0;
    #1;
    chk("wb_fwd_a", {30'd0, forward_a}, 32'b01);
    chk("wb_src_a", src_a, 32'h22);
    clr_bypass();

    // x0 guard
    set_id(1'b1, 32'h104, 32'h0, 32'h5, 32'h0, 5'd0, 5'd6, 5'd1, OPCODE_OP,
           ALU_OP_RTYPE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    rd_mem = 5'd0; reg_write_mem = 1'b1; alu_result_mem = 32'hFFFF_FFFF;
    #1;
    chk("x0_fwd_a", {30'd0, forward_a}, 32'b00);
    chk("x0_src_a", src_a, 32'h0);
    clr_bypass();

    // lw x7,4(x2) then add x8,x7,x1
    set_id(1'b1, 32'h108, 32'h40, 32'h0, 32'h4, 5'd2, 5'd0, 5'd7, OPCODE_LOAD,
           ALU_OP_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("lw_memread", {31'd0, mem_read_ex}, 32'd1);
    set_id(1'b1, 32'h10C, 32'h0, 32'h3, 32'h0, 5'd7, 5'd1, 5'd8, OPCODE_OP,
           ALU_OP_RTYPE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
    tick();
    chk("lu_bub_valid", {31'd0, valid_ex}, 32'd0);
    chk("lu_bub_rw", {31'd0, reg_write_ex}, 32'd0);
    chk("lu_bub_rd", {27'd0, rd_ex}, 32'd0);
    chk("lu_bub_m2r", {31'd0, mem_to_reg_ex}, 32'd0);
    chk("lu_stall_gone", {31'd0, load_use_stall}, 32'd0);
    tick();
    rd_mem = 5'd7; reg_write_mem = 1'b1; alu_result_mem = 32'h77;
    #1;
    chk("lu_add_valid", {31'd0, valid_ex}, 32'd1);
    chk("lu_add_rd", {27'd0, rd_ex}, 32'd8);
    chk("lu_add_fwd_a", {30'd0, forward_a}, 32'b10);
    chk("lu_add_src_a", src_a, 32'h77);
    clr_bypass();

    // Load to x0 never stalls
    set_id(1'b1, 32'h110, 32'h40, 32'h0, 32'h4, 5'd2, 5'd0, 5'd0, OPCODE_LOAD,
           ALU_OP_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(1'b1, 32'h114, 32'h0, 32'h3, 32'h0, 5'd0, 5'd1, 5'd8, OPCODE_OP,
           ALU_OP_RTYPE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("x0_load_nostall", {31'd0, load_use_stall}, 32'd0);
    tick();
    chk("x0_load_next_pc", pc_ex, 32'h114);

    // Flush overrides load-use
    set_id(1'b1, 32'h118, 32'h40, 32'h0, 32'h4, 5'd2, 5'd0, 5'd7, OPCODE_LOAD,
           ALU_OP_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(1'b1, 32'h11C, 32'h0, 32'h3, 32'h0, 5'd7, 5'd1, 5'd8, OPCODE_OP,
           ALU_OP_RTYPE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_nostall", {31'd0, load_use_stall}, 32'd0);
    tick();
    chk("flush_bub_valid", {31'd0, valid_ex}, 32'd0);
    chk("flush_bub_rd", {27'd0, rd_ex}, 32'd0);
    flush = 1'b0;

    // Flush held under stall_in
    set_id(1'b1, 32'h200, 32'h1, 32'h2, 32'h0, 5'd3, 5'd4, 5'd9, OPCODE_OP,
           ALU_OP_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_stall_pc", pc_ex, 32'h200);
    set_id(1'b1, 32'h204, 32'h1, 32'h2, 32'h0, 5'd3, 5'd4, 5'd10, OPCODE_OP,
           ALU_OP_RTYPE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1; stall_in = 1'b1;
    tick();
    tick();
    chk("stall_hold_valid", {31'd0, valid_ex}, 32'd1);
    chk("stall_hold_pc", pc_ex, 32'h200);
    chk("stall_hold_rd", {27'd0, rd_ex}, 32'd9);
    chk("stall_hold_aluop", {30'd0, alu_op_ex}, 32'd1);
    stall_in = 1'b0;
    tick();
    chk("unstall_flush_valid", {31'd0, valid_ex}, 32'd0);
    chk("unstall_flush_rw", {31'd0, reg_write_ex}, 32'd0);
    chk("unstall_flush_aluop", {30'd0, alu_op_ex}, 32'd0);
    flush = 1'b0;

    // sw x9,0x10(x2) with rs2 from WB
    set_id(1'b1, 32'h300, 32'h1000, 32'h1111, 32'h10, 5'd2, 5'd9, 5'd0, OPCODE_STORE,
           ALU_OP_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    rd_wb = 5'd9; reg_write_wb = 1'b1; result_wb = 32'hABCD;
    #1;
    chk("sw_src_b", src_b, 32'h10);
    chk("sw_fwd_b", {30'd0, forward_b}, 32'b01);
    chk("sw_store_data", store_data_ex, 32'hABCD);
    chk("sw_memwrite", {31'd0, mem_write_ex}, 32'd1);
    chk("sw_imm", imm_ex, 32'h10);
    chk("sw_src_a", src_a, 32'h1000);
    clr_bypass();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
